// File: rtl/payload_engine_ctrl.sv
// Payload engine controller: sequences the match engines over a single payload.
// It clears the engines once per packet, gates the engine clock enable per
// accepted byte (up to MAX_LEN bytes), runs DRAIN_CYC extra enable cycles so the
// engines reach their end state, and then reports the captured match vector
// together with the length, truncation and error flags through a valid/ready
// result port.
//
// Ports:
//   clk, rst                 clock (rising edge); asynchronous active-high reset
//   s_valid/s_sop/s_eop      upstream payload beat qualifiers
//   s_ready                  beat accepted when s_valid & s_ready (combinational)
//   eng_sod                  registered engine clear pulse (one cycle, in CLEAR)
//   eng_en                   engine clock enable (combinational, same cycle as beat)
//   eng_match[NUM_ENG]       sticky engine match bits
//   r_valid/r_ready          result handshake
//   r_match/r_len/r_trunc/r_err  registered result payload
//   busy                     controller is not idle
//
// DRAIN_CYC must be at least 1.
module payload_engine_ctrl #(
    parameter int unsigned NUM_ENG   = 8,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned MAX_LEN   = 1460,
    parameter int unsigned DRAIN_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic               s_sop,
    input  logic               s_eop,
    output logic               s_ready,
    output logic               eng_sod,
    output logic               eng_en,
    input  logic [NUM_ENG-1:0] eng_match,
    output logic               r_valid,
    input  logic               r_ready,
    output logic [NUM_ENG-1:0] r_match,
    output logic [LEN_W-1:0]   r_len,
    output logic               r_trunc,
    output logic               r_err,
    output logic               busy
);

    localparam int unsigned DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [LEN_W-1:0] LEN_SAT    = '1;
    localparam logic [LEN_W-1:0] LEN_LIMIT  = LEN_W'(MAX_LEN);
    localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SCAN   = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] len_q;
    logic             trunc_q;
    logic             err_q;
    logic [DCW-1:0]   drain_cnt_q;
    logic             at_limit;

    // Bytes past MAX_LEN are consumed but never clocked into the engines.
    assign at_limit = (len_q >= LEN_LIMIT);
    assign busy     = (state_q != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and combinational handshake/enable outputs
    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        eng_en  = 1'b0;
        case (state_q)
            IDLE: begin
                // Stray non-sop beats are drained; an sop beat is held for SCAN.
                s_ready = s_valid & ~s_sop;
                if (s_valid && s_sop) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = SCAN;
            end
            SCAN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    eng_en = ~at_limit;
                    if (s_eop) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                eng_en = ~trunc_q;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (r_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-packet length, flags and drain counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q       <= '0;
            trunc_q     <= 1'b0;
            err_q       <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    len_q       <= '0;
                    trunc_q     <= 1'b0;
                    err_q       <= 1'b0;
                    drain_cnt_q <= '0;
                end
                SCAN: begin
                    if (s_valid) begin
                        if (len_q != LEN_SAT) begin
                            len_q <= len_q + LEN_W'(1);
                        end
                        if (at_limit) begin
                            trunc_q <= 1'b1;
                        end
                        // The first beat legitimately carries sop; eop on the same beat wins.
                        if (s_sop && !s_eop && (len_q != '0)) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt_q <= drain_cnt_q + DCW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Registered engine clear and result port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_sod <= 1'b0;
            r_valid <= 1'b0;
            r_match <= '0;
            r_len   <= '0;
            r_trunc <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            eng_sod <= (state_d == CLEAR);
            r_valid <= (state_d == REPORT);
            if ((state_q == DRAIN) && (state_d == REPORT)) begin
                r_match <= eng_match;
                r_len   <= len_q;
                r_trunc <= trunc_q;
                r_err   <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_payload_engine_ctrl.sv
// Testbench for payload_engine_ctrl: directed and random packets checked
// against a packet-level reference computed from length/sop positions.
module tb_payload_engine_ctrl;

    localparam int NE  = 8;
    localparam int LW  = 4;
    localparam int ML  = 4;
    localparam int DC  = 2;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_sop;
    logic          s_eop;
    logic          s_ready;
    logic          eng_sod;
    logic          eng_en;
    logic [NE-1:0] eng_match;
    logic          r_valid;
    logic          r_ready;
    logic [NE-1:0] r_match;
    logic [LW-1:0] r_len;
    logic          r_trunc;
    logic          r_err;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    int sod_cnt  = 0;

    payload_engine_ctrl #(
        .NUM_ENG  (NE),
        .LEN_W    (LW),
        .MAX_LEN  (ML),
        .DRAIN_CYC(DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_sop    (s_sop),
        .s_eop    (s_eop),
        .s_ready  (s_ready),
        .eng_sod  (eng_sod),
        .eng_en   (eng_en),
        .eng_match(eng_match),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r_match  (r_match),
        .r_len    (r_len),
        .r_trunc  (r_trunc),
        .r_err    (r_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Cycle counts of the engine strobes, sampled mid-cycle
    always @(negedge clk) begin
        if (eng_en === 1'b1) en_cnt++;
        if (eng_sod === 1'b1) sod_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat and wait (bounded) for it to be accepted.
    task automatic send_beat(input logic sop, input logic eop, input logic exp_en);
        int t;
        s_valid = 1'b1;
        s_sop   = sop;
        s_eop   = eop;
        t = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("beat_accept_timeout", 32'(t < 40), 32'd1);
        chk("eng_en_beat", 32'(eng_en), 32'(exp_en));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
    endtask

    // Send a packet of n bytes (extra sop at sop_pos), hold r_ready low for
    // hold cycles in REPORT, and check the result against the packet rules.
    task automatic run_pkt(input int n, input int sop_pos, input int hold, input logic [NE-1:0] match);
        int   en0;
        int   sod0;
        int   t;
        int   exp_len;
        int   exp_en;
        logic exp_trunc;
        logic exp_err;
        exp_trunc = (n > ML);
        exp_len   = (n > SAT) ? SAT : n;
        exp_err   = (sop_pos >= 1) && (sop_pos <= n - 2);
        exp_en    = ((n > ML) ? ML : n) + (exp_trunc ? 0 : DC);
        eng_match = '0;
        en0  = en_cnt;
        sod0 = sod_cnt;
        for (int i = 0; i < n; i++) begin
            send_beat((i == 0) || (i == sop_pos), i == n - 1, i < ML);
        end
        eng_match = match;
        @(negedge clk);
        t = 1;
        while (r_valid !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("report_latency", 32'(t), 32'(DC + 1));
        chk("sod_pulses", 32'(sod_cnt - sod0), 32'd1);
        chk("en_cycles", 32'(en_cnt - en0), 32'(exp_en));
        for (int c = 0; c <= hold; c++) begin
            chk("r_valid_hold", 32'(r_valid), 32'd1);
            chk("r_match", 32'(r_match), 32'(match));
            chk("r_len", 32'(r_len), 32'(exp_len));
            chk("r_trunc", 32'(r_trunc), 32'(exp_trunc));
            chk("r_err", 32'(r_err), 32'(exp_err));
            chk("s_ready_report", 32'(s_ready), 32'd0);
            chk("sod_report", 32'(eng_sod), 32'd0);
            chk("busy_report", 32'(busy), 32'd1);
            if (c < hold) begin
                s_valid = 1'b1;
                s_sop   = 1'b1;
            end else begin
                s_valid = 1'b0;
                s_sop   = 1'b0;
                r_ready = 1'b1;
            end
            @(negedge clk);
        end
        r_ready = 1'b0;
        chk("r_valid_after_hs", 32'(r_valid), 32'd0);
        chk("busy_after_hs", 32'(busy), 32'd0);
        @(negedge clk);
        chk("single_report", 32'(r_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int sp;
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_sop     = 1'b0;
        s_eop     = 1'b0;
        r_ready   = 1'b0;
        eng_match = '0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_eng_sod", 32'(eng_sod), 32'd0);
        chk("rst_eng_en", 32'(eng_en), 32'd0);
        chk("rst_r_len", 32'(r_len), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 3-byte packet, match 0x04
        run_pkt(3, -1, 0, 8'h04);
        // truncation: 6 bytes with MAX_LEN=4
        run_pkt(6, -1, 0, 8'h5A);
        // consumer stalls 5 cycles
        run_pkt(2, -1, 5, 8'hC3);
        // stray beats in IDLE, then a packet
        send_beat(1'b0, 1'b0, 1'b0);
        send_beat(1'b0, 1'b1, 1'b0);
        chk("stray_not_busy", 32'(busy), 32'd0);
        run_pkt(3, -1, 0, 8'h81);
        // sop on byte 2 of 4
        run_pkt(4, 1, 0, 8'h10);
        // sop together with eop: eop wins, no error
        run_pkt(3, 2, 0, 8'h22);
        // length saturation
        run_pkt(20, -1, 1, 8'hFF);
        // minimum packet
        run_pkt(1, -1, 0, 8'h01);

        // reset in the middle of SCAN
        eng_match = 8'hFF;
        send_beat(1'b1, 1'b0, 1'b1);
        send_beat(1'b0, 1'b0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_eng_en", 32'(eng_en), 32'd0);
        chk("mid_rst_eng_sod", 32'(eng_sod), 32'd0);
        chk("mid_rst_r_valid", 32'(r_valid), 32'd0);
        chk("mid_rst_r_match", 32'(r_match), 32'd0);
        chk("mid_rst_r_len", 32'(r_len), 32'd0);
        chk("mid_rst_r_trunc", 32'(r_trunc), 32'd0);
        chk("mid_rst_r_err", 32'(r_err), 32'd0);
        s_valid = 1'b1;
        #1;
        chk("rst_s_ready_nonsop", 32'(s_ready), 32'd1);
        s_sop = 1'b1;
        #1;
        chk("rst_s_ready_sop", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        s_sop   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_report", 32'(r_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        run_pkt(3, -1, 0, 8'h66);

        // random packets
        for (int k = 0; k < 25; k++) begin
            n  = int'($urandom_range(1, 20));
            sp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 19)) : -1;
            if ($urandom_range(0, 3) == 0) begin
                send_beat(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            run_pkt(n, sp, int'($urandom_range(0, 3)), NE'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
